hazard_unit: RTL and testbench



---
 rtl/hazard_unit_pkg.sv | 34 +++
 rtl/hazard_unit_if.sv | 52 +++++
 rtl/hazard_unit_muldiv_timer.sv | 81 ++++++++
 rtl/hazard_unit.sv | 90 +++++++++
 tb/tb_hazard_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_pkg
//  Description : Shared types and constants for the MINAv2 hazard/stall
//                controller (register address type, MUL/DIV FSM states).
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_unit_pkg;

    // Architectural register index (32 registers).
    typedef logic [4:0] regaddr_t;

    // r0 is hard-wired to zero and never carries a dependency.
    localparam regaddr_t REG_ZERO = '0;

    // Width of the MUL/DIV occupancy down-counter (covers latency up to 16).
    localparam int unsigned MULDIV_CNT_W = 4;

    // MUL/DIV occupancy FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } hazard_state_e;

    // True when an ID-stage source operand is really read and names rd.
    function automatic logic src_match(input logic used,
                                       input regaddr_t src,
                                       input regaddr_t rd);
        return used && (src == rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_if
//  Description : Pipeline-to-hazard-controller bundle: ID/EX hazard sources in,
//                per-register stall/flush/bubble enables out.
//                master = pipeline side, slave = hazard_unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    // Hazard sources from the ID and EX stages
    regaddr_t ra_addr_if_id;
    regaddr_t rb_addr_if_id;
    logic     ra_used_if_id;
    logic     rb_used_if_id;
    logic     valid_id_ex;
    logic     mem_read_id_ex;
    regaddr_t rd_addr_id_ex;
    logic     muldiv_id_ex;
    logic     branch_taken_ex;
    logic     mem_wait;

    // Pipeline register controls
    logic     pc_stall;
    logic     if_id_stall;
    logic     id_ex_stall;
    logic     ex_mem_stall;
    logic     mem_wb_stall;
    logic     if_id_flush;
    logic     id_ex_bubble;
    logic     ex_mem_bubble;
    logic     muldiv_busy;

    modport master (
        output ra_addr_if_id, rb_addr_if_id, ra_used_if_id, rb_used_if_id,
               valid_id_ex, mem_read_id_ex, rd_addr_id_ex, muldiv_id_ex,
               branch_taken_ex, mem_wait,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_flush, id_ex_bubble, ex_mem_bubble, muldiv_busy
    );

    modport slave (
        input  ra_addr_if_id, rb_addr_if_id, ra_used_if_id, rb_used_if_id,
               valid_id_ex, mem_read_id_ex, rd_addr_id_ex, muldiv_id_ex,
               branch_taken_ex, mem_wait,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_flush, id_ex_bubble, ex_mem_bubble, muldiv_busy
    );

endinterface
`default_nettype wire

// File: rtl/hazard_unit_muldiv_timer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_timer
//  Description : Tracks how long a MUL/DIV op occupies EX. Stall is raised
//                from the entry cycle for LATENCY-1 cycles; the op leaves EX
//                in the following (DONE) cycle. freeze holds state and count.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_timer
    import hazard_unit_pkg::*;
#(
    parameter int unsigned LATENCY = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic start,
    input  wire logic freeze,
    output logic      stall,
    output logic      busy
);

    // Entry cycle is spent in IDLE and the last stall cycle sees cnt==0,
    // so BUSY is loaded with LATENCY-3 to give LATENCY-1 stall cycles.
    localparam logic [MULDIV_CNT_W-1:0] c_cnt_load =
        (LATENCY > 2) ? MULDIV_CNT_W'(LATENCY - 3) : '0;

    hazard_state_e             r_state;
    hazard_state_e             w_state_nxt;
    logic [MULDIV_CNT_W-1:0]   r_cnt;
    logic [MULDIV_CNT_W-1:0]   w_cnt_nxt;

    // State and counter register; held while data memory is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (!freeze) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter update and stall request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    if (LATENCY == 2) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                // The op leaves EX now; never retrigger on it.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : MINAv2 hazard and stall controller. Resolves the hazards
//                forwarding cannot: data-memory wait, MUL/DIV occupancy,
//                taken-branch wrong path and load-use, in that priority.
//                Optional feature macro: HAZARD_MULDIV_EN (MUL/DIV timer).
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    hazard_unit_if.slave  hz
);

    logic w_load_use;
    logic w_muldiv_stall;
    logic w_muldiv_busy;

    // A load in EX feeding an operand actually read in ID; r0 is exempt.
    assign w_load_use = hz.valid_id_ex && hz.mem_read_id_ex &&
                        (hz.rd_addr_id_ex != REG_ZERO) &&
                        (src_match(hz.ra_used_if_id, hz.ra_addr_if_id, hz.rd_addr_id_ex) ||
                         src_match(hz.rb_used_if_id, hz.rb_addr_if_id, hz.rd_addr_id_ex));

`ifdef HAZARD_MULDIV_EN
    muldiv_timer #(
        .LATENCY (MULDIV_LATENCY)
    ) u_muldiv_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (hz.valid_id_ex && hz.muldiv_id_ex),
        .freeze (hz.mem_wait),
        .stall  (w_muldiv_stall),
        .busy   (w_muldiv_busy)
    );
`else
    // No MUL/DIV timer: the op is treated as single-cycle.
    localparam int unsigned c_latency_unused = MULDIV_LATENCY;
    logic [1:0] w_unused;
    assign w_unused       = {clk, hz.muldiv_id_ex};
    assign w_muldiv_stall = 1'b0;
    assign w_muldiv_busy  = 1'b0;
`endif

    // Priority encoder driving every pipeline register control.
    always_comb begin
        hz.pc_stall      = 1'b0;
        hz.if_id_stall   = 1'b0;
        hz.id_ex_stall   = 1'b0;
        hz.ex_mem_stall  = 1'b0;
        hz.mem_wb_stall  = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_bubble  = 1'b0;
        hz.ex_mem_bubble = 1'b0;
        hz.muldiv_busy   = 1'b0;
        if (rst_n) begin
            hz.muldiv_busy = w_muldiv_busy;
            if (hz.mem_wait) begin
                // Freeze the whole pipe until data memory answers.
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_stall  = 1'b1;
                hz.ex_mem_stall = 1'b1;
                hz.mem_wb_stall = 1'b1;
            end else if (w_muldiv_stall) begin
                // Hold the op in EX; a taken branch waits for it to finish.
                hz.pc_stall      = 1'b1;
                hz.if_id_stall   = 1'b1;
                hz.id_ex_stall   = 1'b1;
                hz.ex_mem_bubble = 1'b1;
            end else if (hz.branch_taken_ex) begin
                // Squash both wrong-path instructions, including any load-use.
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                // One bubble; the load result is forwarded from MEM/WB after.
                hz.pc_stall     = 1'b1;
                hz.if_id_stall  = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Directed self-checking bench for hazard_unit. Three DUTs
//                (MUL/DIV latency 8, 2, 4) share the ID/EX stimulus; each
//                gets its own muldiv_id_ex. MUL/DIV scenarios follow the
//                HAZARD_MULDIV_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb stalls,
    // if_id_flush, id_ex_bubble, ex_mem_bubble, muldiv_busy.
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_LU   = 9'b110000100;
    localparam logic [8:0] E_BR   = 9'b000001100;
    localparam logic [8:0] E_MW   = 9'b111110000;
    localparam logic [8:0] E_MD   = 9'b111000010;
    localparam logic [8:0] E_BUSY = 9'b000000001;

    logic     clk = 1'b0;
    logic     rst_n;
    regaddr_t ra, rb, rd;
    logic     ra_used, rb_used, valid, mem_read, br, mw;
    logic     md8, md2, md4;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_v;
    logic [8:0] got_v;

    always #5 clk = ~clk;

    hazard_unit_if if8();
    hazard_unit_if if2();
    hazard_unit_if if4();

    assign if8.ra_addr_if_id = ra;   assign if2.ra_addr_if_id = ra;   assign if4.ra_addr_if_id = ra;
    assign if8.rb_addr_if_id = rb;   assign if2.rb_addr_if_id = rb;   assign if4.rb_addr_if_id = rb;
    assign if8.ra_used_if_id = ra_used; assign if2.ra_used_if_id = ra_used; assign if4.ra_used_if_id = ra_used;
    assign if8.rb_used_if_id = rb_used; assign if2.rb_used_if_id = rb_used; assign if4.rb_used_if_id = rb_used;
    assign if8.valid_id_ex = valid;  assign if2.valid_id_ex = valid;  assign if4.valid_id_ex = valid;
    assign if8.mem_read_id_ex = mem_read; assign if2.mem_read_id_ex = mem_read; assign if4.mem_read_id_ex = mem_read;
    assign if8.rd_addr_id_ex = rd;   assign if2.rd_addr_id_ex = rd;   assign if4.rd_addr_id_ex = rd;
    assign if8.branch_taken_ex = br; assign if2.branch_taken_ex = br; assign if4.branch_taken_ex = br;
    assign if8.mem_wait = mw;        assign if2.mem_wait = mw;        assign if4.mem_wait = mw;
    assign if8.muldiv_id_ex = md8;   assign if2.muldiv_id_ex = md2;   assign if4.muldiv_id_ex = md4;

    hazard_unit #(.MULDIV_LATENCY(8)) dut8 (.clk(clk), .rst_n(rst_n), .hz(if8));
    hazard_unit #(.MULDIV_LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .hz(if2));
    hazard_unit #(.MULDIV_LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .hz(if4));

    function automatic logic [8:0] outs(input int sel);
        case (sel)
            2:       return {if2.pc_stall, if2.if_id_stall, if2.id_ex_stall, if2.ex_mem_stall,
                             if2.mem_wb_stall, if2.if_id_flush, if2.id_ex_bubble,
                             if2.ex_mem_bubble, if2.muldiv_busy};
            4:       return {if4.pc_stall, if4.if_id_stall, if4.id_ex_stall, if4.ex_mem_stall,
                             if4.mem_wb_stall, if4.if_id_flush, if4.id_ex_bubble,
                             if4.ex_mem_bubble, if4.muldiv_busy};
            default: return {if8.pc_stall, if8.if_id_stall, if8.id_ex_stall, if8.ex_mem_stall,
                             if8.mem_wb_stall, if8.if_id_flush, if8.id_ex_bubble,
                             if8.ex_mem_bubble, if8.muldiv_busy};
        endcase
    endfunction

    task automatic clear_inputs();
        ra = '0; rb = '0; rd = '0;
        ra_used = 1'b0; rb_used = 1'b0; valid = 1'b0; mem_read = 1'b0;
        br = 1'b0; mw = 1'b0; md8 = 1'b0; md2 = 1'b0; md4 = 1'b0;
    endtask

    task automatic set_load_use_r3();
        valid = 1'b1; mem_read = 1'b1; rd = 5'd3; ra = 5'd3; ra_used = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_load_use_r3();
        mw = 1'b1;
        md8 = 1'b1; md4 = 1'b1;
        @(negedge clk);
        got_v = outs(8); n_checks++;
        if (got_v !== E_NONE) $display("FAIL reset_hold_l8 got=%b exp=%b", got_v, E_NONE);
        else n_pass++;
        got_v = outs(4); n_checks++;
        if (got_v !== E_NONE) $display("FAIL reset_hold_l4 got=%b exp=%b", got_v, E_NONE);
        else n_pass++;
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        got_v = outs(8); n_checks++;
        if (got_v !== E_NONE) $display("FAIL reset_release got=%b exp=%b", got_v, E_NONE);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            set_load_use_r3();
            rb = 5'd7;
            exp_v = E_LU;
            case (i)
                1: begin ra_used = 1'b0; exp_v = E_NONE; end
                2: begin rd = 5'd0; ra = 5'd0; exp_v = E_NONE; end
                3: begin ra_used = 1'b0; rb = 5'd3; rb_used = 1'b1; exp_v = E_LU; end
                4: begin valid = 1'b0; exp_v = E_NONE; end
                5: begin mem_read = 1'b0; exp_v = E_NONE; end
                6: begin ra = 5'd1; rb = 5'd3; rb_used = 1'b0; exp_v = E_NONE; end
                default: ;
            endcase
            @(negedge clk);
            got_v = outs(8); n_checks++;
            if (got_v !== exp_v) $display("FAIL load_use case=%0d got=%b exp=%b", i, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            br = 1'b1;
            exp_v = E_BR;
            if (i >= 1) set_load_use_r3();
            if (i == 2) begin mw = 1'b1; exp_v = E_MW; end
            @(negedge clk);
            got_v = outs(8); n_checks++;
            if (got_v !== exp_v) $display("FAIL branch case=%0d got=%b exp=%b", i, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
        clear_inputs();
    endtask

`ifdef HAZARD_MULDIV_EN
    task automatic test_muldiv_l8();
        clear_inputs();
        valid = 1'b1; md8 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            br = (k == 2);
            if (k == 8) clear_inputs();
            if (k == 0)      exp_v = E_MD;
            else if (k < 7)  exp_v = E_MD | E_BUSY;
            else if (k == 7) exp_v = E_BUSY;
            else             exp_v = E_NONE;
            @(negedge clk);
            got_v = outs(8); n_checks++;
            if (got_v !== exp_v) $display("FAIL muldiv_l8 k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_muldiv_l2();
        clear_inputs();
        valid = 1'b1; md2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) clear_inputs();
            exp_v = (k == 0) ? E_MD : (k == 1) ? E_BUSY : E_NONE;
            @(negedge clk);
            got_v = outs(2); n_checks++;
            if (got_v !== exp_v) $display("FAIL muldiv_l2 k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_mem_wait_busy();
        clear_inputs();
        valid = 1'b1; md8 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mw = (k >= 3 && k <= 5);
            if (k == 11) clear_inputs();
            if (k >= 3 && k <= 5) exp_v = E_MW | E_BUSY;
            else if (k == 0)      exp_v = E_MD;
            else if (k < 10)      exp_v = E_MD | E_BUSY;
            else if (k == 10)     exp_v = E_BUSY;
            else                  exp_v = E_NONE;
            @(negedge clk);
            got_v = outs(8); n_checks++;
            if (got_v !== exp_v) $display("FAIL mem_wait_busy k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        valid = 1'b1; md4 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) clear_inputs();
            case (k)
                0, 4:       exp_v = E_MD;
                1, 2, 5, 6: exp_v = E_MD | E_BUSY;
                3, 7:       exp_v = E_BUSY;
                default:    exp_v = E_NONE;
            endcase
            @(negedge clk);
            got_v = outs(4); n_checks++;
            if (got_v !== exp_v) $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask
`else
    task automatic test_muldiv_disabled();
        clear_inputs();
        valid = 1'b1; md8 = 1'b1; md2 = 1'b1; md4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_v = E_NONE;
            if (k == 3) begin set_load_use_r3(); exp_v = E_LU; end
            @(negedge clk);
            got_v = outs(8); n_checks++;
            if (got_v !== exp_v) $display("FAIL muldiv_off_l8 k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            got_v = outs(4); n_checks++;
            if (got_v !== exp_v) $display("FAIL muldiv_off_l4 k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            next_cycle();
        end
        clear_inputs();
    endtask
`endif

    task automatic test_reset_mid_op();
        clear_inputs();
`ifdef HAZARD_MULDIV_EN
        valid = 1'b1; md8 = 1'b1;
        // Walk to BUSY with cnt=2 (entry cycle + four cycles).
        for (int k = 0; k < 5; k++) begin
            exp_v = (k == 0) ? E_MD : (E_MD | E_BUSY);
            @(negedge clk);
            got_v = outs(8); n_checks++;
            if (got_v !== exp_v) $display("FAIL reset_mid_walk k=%0d got=%b exp=%b", k, got_v, exp_v);
            else n_pass++;
            if (k < 4) next_cycle();
        end
`else
        set_load_use_r3();
        @(negedge clk);
`endif
        // Reset pulse entirely between clock edges.
        #1 rst_n = 1'b0;
        #1;
        got_v = outs(8); n_checks++;
        if (got_v !== E_NONE) $display("FAIL reset_async_drop got=%b exp=%b", got_v, E_NONE);
        else n_pass++;
        #1 rst_n = 1'b1;
        clear_inputs();
        set_load_use_r3();
        #1;
        got_v = outs(8); n_checks++;
        if (got_v !== E_LU) $display("FAIL reset_then_load_use got=%b exp=%b", got_v, E_LU);
        else n_pass++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        got_v = outs(8); n_checks++;
        if (got_v !== E_NONE) $display("FAIL reset_no_residual got=%b exp=%b", got_v, E_NONE);
        else n_pass++;
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
`ifdef HAZARD_MULDIV_EN
        test_muldiv_l8();
        test_muldiv_l2();
        test_mem_wait_busy();
        test_back_to_back();
`else
        test_muldiv_disabled();
`endif
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
